// File: rtl/uart_alu_host.sv
// Host-side initiator for the UART-attached ALU: sends A, B, opcode and returns the result byte.
// Optional result timeout is enabled by defining UART_ALU_HOST_TIMEOUT_EN.
module uart_alu_host #(
    parameter int DATA_BITS      = 8,
    parameter int OPCODE_BITS    = 6,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic [DATA_BITS-1:0]   i_op_a,
    input  logic [DATA_BITS-1:0]   i_op_b,
    input  logic [OPCODE_BITS-1:0] i_op_code,
    output logic                   o_ready,
    output logic [DATA_BITS-1:0]   o_result,
    output logic                   o_done,
    output logic                   o_timeout,
    input  logic                   i_tx_full,
    output logic                   o_wr_uart,
    output logic [DATA_BITS-1:0]   o_w_data,
    input  logic                   i_rx_empty,
    input  logic [DATA_BITS-1:0]   i_r_data,
    output logic                   o_rd_uart
);

    if (OPCODE_BITS > DATA_BITS || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("uart_alu_host: invalid parameter combination");
    end

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SEND_A   = 3'd1,
        SEND_B   = 3'd2,
        SEND_OP  = 3'd3,
        WAIT_RES = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [DATA_BITS-1:0]   a_q, a_d;
    logic [DATA_BITS-1:0]   b_q, b_d;
    logic [OPCODE_BITS-1:0] op_q, op_d;
    logic [DATA_BITS-1:0]   result_q, result_d;
    logic                   done_q, done_d;
    logic                   timeout_q, timeout_d;
    logic                   timeout_hit_s;
    logic                   wr_s;
    logic                   rd_s;
    logic [DATA_BITS-1:0]   wdata_s;

`ifdef UART_ALU_HOST_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Wait counter: zero outside WAIT_RES, so every entry starts from 0.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Counter next value and last-cycle detection.
    always_comb begin
        cnt_d = {CNT_W{1'b0}};
        if (state_q == WAIT_RES && i_rx_empty) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = {CNT_W{1'b0}};
        end
    end

    assign timeout_hit_s = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit_s = 1'b0;
`endif

    // State, latched request and registered result/pulses.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q   <= IDLE;
            a_q       <= {DATA_BITS{1'b0}};
            b_q       <= {DATA_BITS{1'b0}};
            op_q      <= {OPCODE_BITS{1'b0}};
            result_q  <= {DATA_BITS{1'b0}};
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            result_q  <= result_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    // Next state and FIFO strobes; a result byte in the final wait cycle beats the timeout.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        result_d  = result_q;
        done_d    = 1'b0;
        timeout_d = 1'b0;
        wr_s      = 1'b0;
        rd_s      = 1'b0;
        wdata_s   = {DATA_BITS{1'b0}};
        case (state_q)
            IDLE: begin
                rd_s = !i_rx_empty;
                if (i_start) begin
                    a_d     = i_op_a;
                    b_d     = i_op_b;
                    op_d    = i_op_code;
                    state_d = SEND_A;
                end else begin
                    state_d = IDLE;
                end
            end
            SEND_A: begin
                wr_s    = !i_tx_full;
                wdata_s = a_q;
                state_d = wr_s ? SEND_B : SEND_A;
            end
            SEND_B: begin
                wr_s    = !i_tx_full;
                wdata_s = b_q;
                state_d = wr_s ? SEND_OP : SEND_B;
            end
            SEND_OP: begin
                wr_s    = !i_tx_full;
                wdata_s = DATA_BITS'(op_q);
                state_d = wr_s ? WAIT_RES : SEND_OP;
            end
            WAIT_RES: begin
                if (!i_rx_empty) begin
                    rd_s     = 1'b1;
                    result_d = i_r_data;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end else if (timeout_hit_s) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    state_d = WAIT_RES;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_ready   = (state_q == IDLE);
    assign o_wr_uart = wr_s;
    assign o_w_data  = wdata_s;
    assign o_rd_uart = rd_s;
    assign o_result  = result_q;
    assign o_done    = done_q;
    assign o_timeout = timeout_q;

endmodule
